usb_sie_tx: RTL and testbench

//  SIE transmit packet assembler; sits directly upstream of the UTM transmit block on the UTMI tx byte interface.

---
 rtl/usb_sie_tx_if.sv | 28 ++
 rtl/usb_sie_tx.sv | 132 +++++++++++++
 tb/tb_usb_sie_tx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_sie_tx_if.sv
// Bundle of request, payload, status and UTMI transmit signals for the SIE
// tx packet assembler. The slave modport is the assembler's own view.
interface usb_sie_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_pid;
  logic       req_zlp;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_last;
  logic       pl_ready;
  logic       done;
  logic       err_underrun;
  logic       err_overflow;
  logic [7:0] data_in;
  logic       tx_valid;
  logic       tx_ready;

  modport slave (
    input  req_valid, req_pid, req_zlp, pl_data, pl_valid, pl_last, tx_ready,
    output req_ready, pl_ready, done, err_underrun, err_overflow, data_in, tx_valid
  );

  modport master (
    output req_valid, req_pid, req_zlp, pl_data, pl_valid, pl_last, tx_ready,
    input  req_ready, pl_ready, done, err_underrun, err_overflow, data_in, tx_valid
  );
endinterface

// File: rtl/usb_sie_tx.sv
// SIE transmit packet assembler: emits PID, payload and CRC16 bytes over the
// UTMI tx byte handshake, then holds off for inter-packet spacing.
module usb_sie_tx #(
  parameter int MAX_PAYLOAD = 64,
  parameter int EOP_WAIT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  usb_sie_tx_if.slave bus
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int WW = $clog2(EOP_WAIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_WAIT} state_t;

  state_t          state;
  state_t          state_next;
  logic            is_data;
  logic            zlp;
  logic            last_held;
  logic            err_underrun;
  logic            err_overflow;
  logic [15:0]     crc;
  logic [15:0]     crc_out;
  logic [7:0]      data_reg;
  logic [CW-1:0]   byte_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            accept;
  logic            at_max;
  logic            byte_last;
  logic            need_byte;
  logic            fetch;

  // Reflected CRC16 (poly 0x8005), one byte per call, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign accept    = (state == S_IDLE) && bus.req_valid;
  assign at_max    = (byte_cnt == CW'(MAX_PAYLOAD));
  assign byte_last = last_held || at_max;
  assign need_byte = ((state == S_PID) && is_data && !zlp) ||
                     ((state == S_DATA) && !byte_last);
  assign fetch     = need_byte && bus.tx_ready && bus.pl_valid;
  // An underrun packet goes out with a deliberately wrong CRC.
  assign crc_out   = err_underrun ? crc : ~crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (bus.req_valid) state_next = S_PID;
      S_PID:
        if (bus.tx_ready) begin
          if (!is_data)          state_next = S_WAIT;
          else if (zlp)          state_next = S_CRC_LO;
          else if (bus.pl_valid) state_next = S_DATA;
          else                   state_next = S_CRC_LO;
        end
      S_DATA:
        if (bus.tx_ready) begin
          if (byte_last)         state_next = S_CRC_LO;
          else if (!bus.pl_valid) state_next = S_CRC_LO;
        end
      S_CRC_LO: if (bus.tx_ready) state_next = S_CRC_HI;
      S_CRC_HI: if (bus.tx_ready) state_next = S_WAIT;
      S_WAIT:   if (wait_cnt == WW'(EOP_WAIT - 1)) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.tx_valid  = (state == S_PID) || (state == S_DATA) ||
                    (state == S_CRC_LO) || (state == S_CRC_HI);
    bus.pl_ready  = fetch;
    bus.done      = (state == S_WAIT) && (wait_cnt == WW'(EOP_WAIT - 1));
    case (state)
      S_CRC_LO: bus.data_in = crc_out[7:0];
      S_CRC_HI: bus.data_in = crc_out[15:8];
      default:  bus.data_in = data_reg;
    endcase
  end

  assign bus.err_underrun = err_underrun;
  assign bus.err_overflow = err_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_data      <= 1'b0;
      zlp          <= 1'b0;
      last_held    <= 1'b0;
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
      crc          <= 16'hFFFF;
      data_reg     <= 8'h00;
      byte_cnt     <= '0;
      wait_cnt     <= '0;
    end else begin
      if (accept) begin
        is_data      <= (bus.req_pid[1:0] == 2'b11);
        zlp          <= bus.req_zlp;
        last_held    <= 1'b0;
        err_underrun <= 1'b0;
        err_overflow <= 1'b0;
        crc          <= 16'hFFFF;
        data_reg     <= {~bus.req_pid, bus.req_pid};
        byte_cnt     <= '0;
      end else if (fetch) begin
        data_reg  <= bus.pl_data;
        byte_cnt  <= byte_cnt + 1'b1;
        crc       <= crc16_byte(crc, bus.pl_data);
        last_held <= bus.pl_last;
      end
      if (need_byte && bus.tx_ready && !bus.pl_valid) err_underrun <= 1'b1;
      // A full packet whose held byte is not marked last gets truncated here.
      if ((state == S_DATA) && bus.tx_ready && at_max && !last_held) err_overflow <= 1'b1;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_usb_sie_tx.sv
// Bench for usb_sie_tx: table of packet requests, byte scoreboard, plus
// hand-written reset sequences. Two instances cover default and small MAX_PAYLOAD.
module tb_usb_sie_tx;

  localparam int MAX_A  = 64;
  localparam int WAIT_A = 64;
  localparam int MAX_B  = 4;
  localparam int WAIT_B = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_sie_tx_if bus_a ();
  usb_sie_tx_if bus_b ();

  usb_sie_tx #(.MAX_PAYLOAD(MAX_A), .EOP_WAIT(WAIT_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  usb_sie_tx #(.MAX_PAYLOAD(MAX_B), .EOP_WAIT(WAIT_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic       sel = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_pid = 4'h0;
  logic       req_zlp = 1'b0;
  logic [7:0] pl_data = 8'h00;
  logic       pl_valid = 1'b0;
  logic       pl_last = 1'b0;
  logic       tx_ready = 1'b0;

  logic       req_ready, pl_ready, done, err_underrun, err_overflow, tx_valid;
  logic [7:0] data_in;

  assign bus_a.req_valid = req_valid && !sel;
  assign bus_b.req_valid = req_valid && sel;
  assign bus_a.req_pid   = req_pid;
  assign bus_b.req_pid   = req_pid;
  assign bus_a.req_zlp   = req_zlp;
  assign bus_b.req_zlp   = req_zlp;
  assign bus_a.pl_data   = pl_data;
  assign bus_b.pl_data   = pl_data;
  assign bus_a.pl_valid  = pl_valid && !sel;
  assign bus_b.pl_valid  = pl_valid && sel;
  assign bus_a.pl_last   = pl_last;
  assign bus_b.pl_last   = pl_last;
  assign bus_a.tx_ready  = tx_ready;
  assign bus_b.tx_ready  = tx_ready;

  assign req_ready    = sel ? bus_b.req_ready    : bus_a.req_ready;
  assign pl_ready     = sel ? bus_b.pl_ready     : bus_a.pl_ready;
  assign done         = sel ? bus_b.done         : bus_a.done;
  assign err_underrun = sel ? bus_b.err_underrun : bus_a.err_underrun;
  assign err_overflow = sel ? bus_b.err_overflow : bus_a.err_overflow;
  assign tx_valid     = sel ? bus_b.tx_valid     : bus_a.tx_valid;
  assign data_in      = sel ? bus_b.data_in      : bus_a.data_in;

  typedef struct {
    logic             sel;
    logic [3:0]       pid;
    logic             zlp;
    int               n;
    logic [15:0][7:0] pl;
    int               underrun_at;
    logic             exp_underrun;
    logic             exp_overflow;
    logic             tail_chk;
    logic [15:0]      exp_tail;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] exp_q [$];
  int         num_checks = 0;
  int         num_fail = 0;

  function automatic vec_t mkVec(input logic s, input logic [3:0] p, input logic z, input int n,
                                 input logic [7:0] base, input int ua, input logic eu,
                                 input logic eo, input logic tc, input logic [15:0] tail);
    vec_t v;
    v.sel = s; v.pid = p; v.zlp = z; v.n = n; v.underrun_at = ua;
    v.exp_underrun = eu; v.exp_overflow = eo; v.tail_chk = tc; v.exp_tail = tail;
    for (int i = 0; i < 16; i++) v.pl[i] = base + 8'(i);
    return v;
  endfunction

  function automatic logic [15:0] crcModel(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ({1'b0, r[15:1]} ^ 16'hA001) : {1'b0, r[15:1]};
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int maxp, ewait, k, plr, gaps, unstable, src, last_xfer, done_cyc;
    logic is_dat, started, final_seen, after_checked, prev_hold;
    logic [7:0] prev_data, b0, b1, e;
    logic [15:0] crc;

    maxp  = v.sel ? MAX_B : MAX_A;
    ewait = v.sel ? WAIT_B : WAIT_A;
    is_dat = (v.pid[1:0] == 2'b11);
    exp_q.delete();
    exp_q.push_back({~v.pid, v.pid});
    k = 0;
    if (is_dat) begin
      if (v.zlp) k = 0;
      else if (v.underrun_at >= 0) k = v.underrun_at;
      else k = (v.n < maxp) ? v.n : maxp;
      crc = 16'hFFFF;
      for (int i = 0; i < k; i++) begin
        exp_q.push_back(v.pl[i]);
        crc = crcModel(crc, v.pl[i]);
      end
      if (!(v.underrun_at >= 0 && !v.zlp)) crc = ~crc;
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end

    @(negedge clk);
    sel = v.sel; tx_ready = 1'b0; pl_valid = 1'b0;
    #1;
    checkOutput("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1; req_pid = v.pid; req_zlp = v.zlp;
    @(posedge clk);
    #1 req_valid = 1'b0;

    src = 0; plr = 0; gaps = 0; unstable = 0; last_xfer = -1; done_cyc = -1;
    started = 0; final_seen = 0; after_checked = 0; prev_hold = 0;
    prev_data = 8'h00; b0 = 8'h00; b1 = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      tx_ready = ($urandom_range(0, 3) != 0);
      pl_valid = (src < v.n) && (src != v.underrun_at);
      pl_data  = (src < 16) ? v.pl[src] : 8'h00;
      pl_last  = (src == v.n - 1);
      #1;
      if (final_seen && !after_checked) begin
        checkOutput("tx_valid_after_last", int'(tx_valid), 0);
        after_checked = 1;
      end
      if (tx_valid) begin
        started = 1;
        if (prev_hold && data_in != prev_data) unstable++;
      end else if (started && exp_q.size() > 0) gaps++;
      if (pl_ready) begin plr++; src++; end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) checkOutput("extra_byte", int'(data_in), -1);
        else begin
          e = exp_q.pop_front();
          checkOutput("tx_byte", int'(data_in), int'(e));
          b0 = b1; b1 = data_in;
          if (exp_q.size() == 0) begin final_seen = 1; last_xfer = cyc; end
        end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = data_in;
      if (done) begin done_cyc = cyc; break; end
    end
    pl_valid = 1'b0; tx_ready = 1'b0;

    checkOutput("done_seen", int'(done_cyc >= 0), 1);
    checkOutput("done_delay", done_cyc - last_xfer, ewait);
    checkOutput("bytes_left", exp_q.size(), 0);
    checkOutput("pl_ready_count", plr, k);
    checkOutput("err_underrun", int'(err_underrun), int'(v.exp_underrun));
    checkOutput("err_overflow", int'(err_overflow), int'(v.exp_overflow));
    checkOutput("tx_gaps", gaps, 0);
    checkOutput("data_unstable", unstable, 0);
    if (v.tail_chk) checkOutput("crc_tail", int'({b1, b0}), int'(v.exp_tail));
    @(negedge clk);
    checkOutput("done_pulse_end", int'(done), 0);
    checkOutput("req_ready_after", int'(req_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = mkVec(1'b0, 4'h2, 1'b0, 0, 8'h00, -1, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[1] = mkVec(1'b0, 4'hB, 1'b1, 0, 8'h00, -1, 1'b0, 1'b0, 1'b1, 16'h0000);
    vecs[2] = mkVec(1'b0, 4'h3, 1'b0, 9, 8'h31, -1, 1'b0, 1'b0, 1'b1, 16'hB4C8);
    vecs[3] = mkVec(1'b0, 4'h3, 1'b0, 3, 8'hA0,  2, 1'b1, 1'b0, 1'b0, 16'h0000);
    vecs[4] = mkVec(1'b0, 4'hA, 1'b0, 0, 8'h00, -1, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[5] = mkVec(1'b1, 4'h3, 1'b0, 6, 8'h10, -1, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[6] = mkVec(1'b1, 4'hB, 1'b0, 4, 8'h55, -1, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[7] = mkVec(1'b0, 4'hB, 1'b0, 1, 8'hF0, -1, 1'b0, 1'b0, 1'b0, 16'h0000);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_tx_valid", int'(tx_valid), 0);
    checkOutput("rst_data_in", int'(data_in), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err_underrun", int'(err_underrun), 0);
    checkOutput("rst_err_overflow", int'(err_overflow), 0);
    checkOutput("rst_pl_ready", int'(pl_ready), 0);
    checkOutput("rst_req_ready", int'(req_ready), 1);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d pid=0x%0h", i, vecs[i].pid);
      applyStimulus(vecs[i]);
    end

    // Pull reset mid-payload: tx_valid must drop without waiting for a clock edge.
    @(negedge clk);
    sel = 1'b0; req_pid = 4'h3; req_zlp = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; pl_valid = 1'b1; pl_data = 8'h77; pl_last = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 checkOutput("tx_valid_pre_reset", int'(tx_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_tx_valid", int'(tx_valid), 0);
    checkOutput("async_rst_data_in", int'(data_in), 0);
    checkOutput("async_rst_req_ready", int'(req_ready), 1);
    checkOutput("async_rst_pl_ready", int'(pl_ready), 0);
    pl_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(vecs[0]);
    applyStimulus(vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
    $finish;
  end

endmodule
